// File: rtl/dit_fft_iter.sv
// Iterative radix-2 decimation-in-time FFT: bit-reversed sample load, one in-place
// butterfly per clock with run-time twiddles, natural-order combinational readback.
module dit_fft_iter #(
    parameter int LOG2N = 3,
    parameter int DW    = 16,
    parameter int FRAC  = 8
) (
    input  logic                                 clk,
    input  logic                                 RST_N,
    input  logic                                 write,
    input  logic [LOG2N-1:0]                     addr,
    input  logic [DW-1:0]                        din_r,
    input  logic [DW-1:0]                        din_i,
    input  logic                                 tw_write,
    input  logic [((LOG2N > 1) ? LOG2N-1 : 1)-1:0] tw_addr,
    input  logic [DW-1:0]                        tw_r,
    input  logic [DW-1:0]                        tw_i,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 ready,
    output logic                                 ovf,
    input  logic [LOG2N-1:0]                     rd_addr,
    output logic [DW-1:0]                        dout_r,
    output logic [DW-1:0]                        dout_i,
    output logic                                 dbg_state
);

    localparam int N    = 1 << LOG2N;
    localparam int HALF = N / 2;
    localparam int TAW  = (LOG2N > 1) ? LOG2N - 1 : 1;
    localparam int SW   = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int PW   = 2 * DW + 1;

    localparam logic [TAW-1:0]   B_LAST = TAW'(HALF - 1);
    localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);
    localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);
    localparam logic [TAW-1:0]   ONES_T = {TAW{1'b1}};
    localparam logic [PW-1:0]    MAXM   = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t         state;
    logic [SW-1:0]  s;
    logic [TAW-1:0] b;

    logic [DW-1:0] buf_r   [N];
    logic [DW-1:0] buf_i   [N];
    logic [DW-1:0] twr_mem [HALF];
    logic [DW-1:0] twi_mem [HALF];

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    // Sign-magnitude to two's complement; a -0 naturally becomes 0.
    function automatic logic signed [DW-1:0] to_tc(input logic [DW-1:0] v);
        logic signed [DW-1:0] m;
        m = $signed({1'b0, v[DW-2:0]});
        return v[DW-1] ? -m : m;
    endfunction

    // Drop FRAC bits with the magnitude truncated toward zero.
    function automatic logic signed [PW-1:0] scale(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] mag;
        mag = v[PW-1] ? -v : v;
        mag = mag >>> FRAC;
        return v[PW-1] ? -mag : mag;
    endfunction

    // Returns {saturated, sign-magnitude word}; zero always comes out with sign 0.
    function automatic logic [DW:0] sat_sm(input logic signed [PW-1:0] v);
        logic          neg;
        logic          hit;
        logic [PW-1:0] mag;
        neg = v[PW-1];
        mag = neg ? -v : v;
        hit = (mag > MAXM);
        if (hit) mag = MAXM;
        return {hit, neg, mag[DW-2:0]};
    endfunction

    logic [TAW-1:0]      mask_t;
    logic [TAW-1:0]      j_t;
    logic [TAW-1:0]      tw_idx;
    logic [LOG2N-1:0]    top;
    logic [LOG2N-1:0]    bot;
    logic signed [PW-1:0] a_r, a_i, b_r, b_i, w_r, w_i, p_r, p_i;
    logic [DW:0]          o_tr, o_ti, o_br, o_bi;
    logic                 sat_any;

    always_comb begin
        mask_t = ~(ONES_T << s);
        j_t    = b & mask_t;
        top    = LOG2N'({(b & ~mask_t), 1'b0}) | LOG2N'(j_t);
        bot    = top | (ONE << s);
        tw_idx = j_t << (LOG2N - 1 - int'(s));

        a_r = PW'(to_tc(buf_r[top]));
        a_i = PW'(to_tc(buf_i[top]));
        b_r = PW'(to_tc(buf_r[bot]));
        b_i = PW'(to_tc(buf_i[bot]));
        w_r = PW'(to_tc(twr_mem[tw_idx]));
        w_i = PW'(to_tc(twi_mem[tw_idx]));

        p_r = scale(w_r * b_r - w_i * b_i);
        p_i = scale(w_r * b_i + w_i * b_r);

        o_tr = sat_sm(a_r + p_r);
        o_ti = sat_sm(a_i + p_i);
        o_br = sat_sm(a_r - p_r);
        o_bi = sat_sm(a_i - p_i);
        sat_any = o_tr[DW] | o_ti[DW] | o_br[DW] | o_bi[DW];
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && write) begin
            buf_r[bitrev(addr)] <= din_r;
            buf_i[bitrev(addr)] <= din_i;
        end else if (state == RUN) begin
            buf_r[top] <= o_tr[DW-1:0];
            buf_i[top] <= o_ti[DW-1:0];
            buf_r[bot] <= o_br[DW-1:0];
            buf_i[bot] <= o_bi[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (tw_write) begin
            twr_mem[tw_addr] <= tw_r;
            twi_mem[tw_addr] <= tw_i;
        end
    end

    // Control contract: in IDLE a write wins over start and drops ready; start alone
    // launches a transform; ready then holds until the next accepted write/start or reset.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            s     <= '0;
            b     <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (write) begin
                        ready <= 1'b0;
                    end else if (start) begin
                        state <= RUN;
                        s     <= '0;
                        b     <= '0;
                        busy  <= 1'b1;
                        ready <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                RUN: begin
                    if (sat_any) ovf <= 1'b1;
                    if (b == B_LAST) begin
                        b <= '0;
                        if (s == S_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            ready <= 1'b1;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end else begin
                        b <= b + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dout_r    = buf_r[rd_addr];
    assign dout_i    = buf_i[rd_addr];
    assign dbg_state = (state == RUN);

endmodule

// File: tb/tb_dit_fft_iter.sv
// Bench for dit_fft_iter: 8-point and 16-point instances checked against a
// stage-by-stage array FFT model with Q8 truncation and saturation.
module tb_dit_fft_iter;

    localparam int     DW    = 16;
    localparam longint SCALE = 256;
    localparam longint MAXM  = 32767;

    logic clk;
    logic rst_n;

    logic          w8, tw8, st8, busy8, ready8, ovf8, dbg8;
    logic [2:0]    a8, rd8;
    logic [1:0]    ta8;
    logic [DW-1:0] dr8, di8, tr8, ti8, or8, oi8;

    logic          w16, tw16, st16, busy16, ready16, ovf16, dbg16;
    logic [3:0]    a16, rd16;
    logic [2:0]    ta16;
    logic [DW-1:0] dr16, di16, tr16, ti16, or16, oi16;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    bit            exp_ovf;
    logic [DW-1:0] smp_r [16];
    logic [DW-1:0] smp_i [16];
    logic [DW-1:0] twv_r [2][8];
    logic [DW-1:0] twv_i [2][8];

    dit_fft_iter #(.LOG2N(3), .DW(DW), .FRAC(8)) dut8 (
        .clk(clk), .RST_N(rst_n), .write(w8), .addr(a8), .din_r(dr8), .din_i(di8),
        .tw_write(tw8), .tw_addr(ta8), .tw_r(tr8), .tw_i(ti8), .start(st8),
        .busy(busy8), .ready(ready8), .ovf(ovf8), .rd_addr(rd8),
        .dout_r(or8), .dout_i(oi8), .dbg_state(dbg8)
    );

    dit_fft_iter #(.LOG2N(4), .DW(DW), .FRAC(8)) dut16 (
        .clk(clk), .RST_N(rst_n), .write(w16), .addr(a16), .din_r(dr16), .din_i(di16),
        .tw_write(tw16), .tw_addr(ta16), .tw_r(tr16), .tw_i(ti16), .start(st16),
        .busy(busy16), .ready(ready16), .ovf(ovf16), .rd_addr(rd16),
        .dout_r(or16), .dout_i(oi16), .dbg_state(dbg16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic get_busy(input int n);
        return (n == 8) ? busy8 : busy16;
    endfunction
    function automatic logic get_ready(input int n);
        return (n == 8) ? ready8 : ready16;
    endfunction
    function automatic logic get_ovf(input int n);
        return (n == 8) ? ovf8 : ovf16;
    endfunction

    // ---------------- reference model ----------------
    function automatic int brev(input int v, input int lg);
        int r = 0;
        for (int i = 0; i < lg; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    function automatic longint sm2i(input logic [DW-1:0] v);
        longint m;
        m = longint'(v[14:0]);
        return v[15] ? -m : m;
    endfunction

    function automatic logic [DW-1:0] i2sm(input longint v);
        if (v < 0) return {1'b1, 15'(-v)};
        return {1'b0, 15'(v)};
    endfunction

    function automatic longint sat(input longint v);
        if (v > MAXM) begin
            exp_ovf = 1'b1;
            return MAXM;
        end
        if (v < -MAXM) begin
            exp_ovf = 1'b1;
            return -MAXM;
        end
        return v;
    endfunction

    task automatic model_fft(input int n);
        longint xr [16];
        longint xi [16];
        longint wr, wi, pr, pim, ar, ai;
        int lg, half, a, c, sel;
        lg  = $clog2(n);
        sel = (n == 16) ? 1 : 0;
        exp_ovf = 1'b0;
        for (int k = 0; k < n; k++) begin
            xr[k] = sm2i(smp_r[brev(k, lg)]);
            xi[k] = sm2i(smp_i[brev(k, lg)]);
        end
        for (int len = 2; len <= n; len = len * 2) begin
            half = len / 2;
            for (int st = 0; st < n; st += len) begin
                for (int j = 0; j < half; j++) begin
                    wr  = sm2i(twv_r[sel][j * (n / len)]);
                    wi  = sm2i(twv_i[sel][j * (n / len)]);
                    a   = st + j;
                    c   = a + half;
                    pr  = (wr * xr[c] - wi * xi[c]) / SCALE;
                    pim = (wr * xi[c] + wi * xr[c]) / SCALE;
                    ar  = xr[a];
                    ai  = xi[a];
                    xr[a] = sat(ar + pr);
                    xi[a] = sat(ai + pim);
                    xr[c] = sat(ar - pr);
                    xi[c] = sat(ai - pim);
                end
            end
        end
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(i2sm(xr[k]));
            exp_q.push_back(i2sm(xi[k]));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic load_sample(input int n, input int a, input logic [DW-1:0] r,
                               input logic [DW-1:0] i);
        @(negedge clk);
        if (n == 8) begin
            w8 = 1'b1; a8 = 3'(a); dr8 = r; di8 = i;
        end else begin
            w16 = 1'b1; a16 = 4'(a); dr16 = r; di16 = i;
        end
        @(negedge clk);
        w8  = 1'b0;
        w16 = 1'b0;
    endtask

    task automatic load_frame(input int n);
        for (int m = 0; m < n; m++) load_sample(n, m, smp_r[m], smp_i[m]);
    endtask

    task automatic load_tw(input int n);
        for (int k = 0; k < n / 2; k++) begin
            @(negedge clk);
            if (n == 8) begin
                tw8 = 1'b1; ta8 = 2'(k); tr8 = twv_r[0][k]; ti8 = twv_i[0][k];
            end else begin
                tw16 = 1'b1; ta16 = 3'(k); tr16 = twv_r[1][k]; ti16 = twv_i[1][k];
            end
            @(negedge clk);
            tw8  = 1'b0;
            tw16 = 1'b0;
        end
    endtask

    // mode 0: plain run, 1: start/write pulsed mid-run, 2: reset at T5
    task automatic run_fft(input int n, input int mode, input string tag);
        int  k, t;
        bit  seen;
        k = (n / 2) * $clog2(n);
        @(negedge clk);
        if (n == 8) st8 = 1'b1; else st16 = 1'b1;
        @(negedge clk);
        st8  = 1'b0;
        st16 = 1'b0;
        t    = 0;
        seen = 1'b0;
        while (!seen && t <= k + 16) begin
            if (get_ready(n)) begin
                seen = 1'b1;
            end else begin
                check($sformatf("%s_busy_t%0d", tag, t), get_busy(n), 1);
                if (t == 0) check({tag, "_ovf_cleared"}, get_ovf(n), 0);
                if (t == 0 && n == 8) check({tag, "_dbg_run"}, dbg8, 1);
                if (mode == 1 && t == 3) begin
                    w8 = 1'b1; st8 = 1'b1; a8 = 3'($urandom_range(0, 7));
                    dr8 = 16'h7FFF; di8 = 16'h7FFF;
                end
                if (mode == 1 && t == 4) begin
                    w8 = 1'b0; st8 = 1'b0;
                end
                if (mode == 2 && t == 5) begin
                    rst_n = 1'b0;
                    #1;
                    check({tag, "_rst_busy"}, busy8, 0);
                    check({tag, "_rst_ready"}, ready8, 0);
                    check({tag, "_rst_ovf"}, ovf8, 0);
                    check({tag, "_rst_dbg"}, dbg8, 0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                @(negedge clk);
                t++;
            end
        end
        check({tag, "_ready_seen"}, seen, 1);
        check({tag, "_latency"}, t, k);
        check({tag, "_busy_end"}, get_busy(n), 0);
    endtask

    task automatic read_word(input int n, input int k, output logic [DW-1:0] r,
                             output logic [DW-1:0] i);
        @(negedge clk);
        if (n == 8) rd8 = 3'(k); else rd16 = 4'(k);
        #1;
        r = (n == 8) ? or8 : or16;
        i = (n == 8) ? oi8 : oi16;
    endtask

    task automatic read_check(input int n, input string tag);
        logic [DW-1:0] r, i;
        for (int k = 0; k < n; k++) begin
            read_word(n, k, r, i);
            check($sformatf("%s_X%0d_r", tag, k), r, exp_q.pop_front());
            check($sformatf("%s_X%0d_i", tag, k), i, exp_q.pop_front());
        end
        check({tag, "_ovf"}, get_ovf(n), exp_ovf);
    endtask

    function automatic logic [DW-1:0] rand_small();
        return {1'($urandom_range(0, 1)), 4'b0, 11'($urandom_range(0, 2047))};
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        logic [DW-1:0] r, i;
        rst_n = 1'b0;
        w8 = 0; tw8 = 0; st8 = 0; a8 = 0; rd8 = 0; ta8 = 0;
        dr8 = 0; di8 = 0; tr8 = 0; ti8 = 0;
        w16 = 0; tw16 = 0; st16 = 0; a16 = 0; rd16 = 0; ta16 = 0;
        dr16 = 0; di16 = 0; tr16 = 0; ti16 = 0;

        twv_r[0] = '{16'h0100, 16'h00B5, 16'h0000, 16'h80B5, 0, 0, 0, 0};
        twv_i[0] = '{16'h0000, 16'h80B5, 16'h8100, 16'h80B5, 0, 0, 0, 0};
        twv_r[1] = '{16'h0100, 16'h00ED, 16'h00B5, 16'h0062,
                     16'h0000, 16'h8062, 16'h80B5, 16'h80ED};
        twv_i[1] = '{16'h0000, 16'h8062, 16'h80B5, 16'h80ED,
                     16'h8100, 16'h80ED, 16'h80B5, 16'h8062};

        repeat (3) @(negedge clk);
        check("reset_busy8", busy8, 0);
        check("reset_ready8", ready8, 0);
        check("reset_ovf8", ovf8, 0);
        check("reset_busy16", busy16, 0);
        check("reset_ready16", ready16, 0);
        check("reset_ovf16", ovf16, 0);
        rst_n = 1'b1;

        load_tw(8);
        load_tw(16);

        // real 8-point
        smp_r = '{16'h0500, 16'h0600, 16'h0400, 16'h0400, 16'h0700, 16'h0600,
                  16'h0700, 16'h0900, 0, 0, 0, 0, 0, 0, 0, 0};
        smp_i = '{default: '0};
        load_frame(8);
        model_fft(8);
        run_fft(8, 0, "real8");
        read_check(8, "real8");
        read_word(8, 0, r, i);
        check("real8_X0_const", {r, i}, {16'h3000, 16'h0000});
        read_word(8, 2, r, i);
        check("real8_X2_const", {r, i}, {16'h0100, 16'h0100});
        read_word(8, 4, r, i);
        check("real8_X4_const", {r, i}, {16'h8200, 16'h0000});
        read_word(8, 6, r, i);
        check("real8_X6_const", {r, i}, {16'h0100, 16'h8100});
        check("real8_ready_hold", ready8, 1);

        // impulse; the first accepted write drops ready
        smp_r = '{default: '0};
        smp_r[0] = 16'h0100;
        load_sample(8, 0, smp_r[0], smp_i[0]);
        check("write_clears_ready", ready8, 0);
        load_frame(8);
        model_fft(8);
        run_fft(8, 0, "impulse");
        read_check(8, "impulse");

        // saturation, then a new start clears ovf
        for (int m = 0; m < 8; m++) smp_r[m] = 16'h7F00;
        load_frame(8);
        model_fft(8);
        run_fft(8, 0, "sat");
        read_check(8, "sat");
        read_word(8, 0, r, i);
        check("sat_X0_r_const", r, 16'h7FFF);
        check("sat_ovf_const", ovf8, 1);
        for (int m = 0; m < 8; m++) begin
            smp_r[m] = rand_small();
            smp_i[m] = rand_small();
        end
        load_frame(8);
        check("ovf_kept_by_write", ovf8, 1);
        model_fft(8);
        run_fft(8, 1, "ctl_ignored");
        read_check(8, "ctl_ignored");

        // write and start together in IDLE: sample stored, no transform
        @(negedge clk);
        w8 = 1'b1; st8 = 1'b1; a8 = 3'd3; dr8 = 16'h1234; di8 = 16'h0056;
        @(negedge clk);
        w8 = 1'b0; st8 = 1'b0;
        check("ws_busy", busy8, 0);
        check("ws_ready", ready8, 0);
        @(negedge clk);
        check("ws_busy_later", busy8, 0);
        read_word(8, 6, r, i);
        check("ws_stored", {r, i}, {16'h1234, 16'h0056});

        // reset mid-run, then reload and rerun with retained twiddles
        smp_r = '{16'h0500, 16'h0600, 16'h0400, 16'h0400, 16'h0700, 16'h0600,
                  16'h0700, 16'h0900, 0, 0, 0, 0, 0, 0, 0, 0};
        smp_i = '{default: '0};
        load_frame(8);
        run_fft(8, 2, "midrst");
        load_frame(8);
        model_fft(8);
        run_fft(8, 0, "after_rst");
        read_check(8, "after_rst");

        // 16-point DC sweep
        for (int m = 0; m < 16; m++) begin
            smp_r[m] = 16'h0100;
            smp_i[m] = 16'h0000;
        end
        load_frame(16);
        model_fft(16);
        run_fft(16, 0, "dc16");
        read_check(16, "dc16");
        read_word(16, 0, r, i);
        check("dc16_X0_const", r, 16'h1000);

        // random 16-point with true twiddles
        for (int m = 0; m < 16; m++) begin
            smp_r[m] = rand_small();
            smp_i[m] = rand_small();
        end
        load_frame(16);
        model_fft(16);
        run_fft(16, 0, "rand16");
        read_check(16, "rand16");

        // random 8-point with arbitrary twiddles and full-range samples
        for (int k = 0; k < 4; k++) begin
            twv_r[0][k] = 16'($urandom());
            twv_i[0][k] = 16'($urandom());
        end
        load_tw(8);
        for (int trial = 0; trial < 3; trial++) begin
            for (int m = 0; m < 8; m++) begin
                smp_r[m] = (trial == 0) ? 16'($urandom()) : rand_small();
                smp_i[m] = (trial == 2) ? 16'h8000 : 16'($urandom_range(0, 16'h0FFF));
            end
            load_frame(8);
            model_fft(8);
            run_fft(8, 0, $sformatf("rand8_%0d", trial));
            read_check(8, $sformatf("rand8_%0d", trial));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
